// File: rtl/aes_pkg.sv
// Shared AES definitions: key/round sizes, round-index type and GF(2^8) xtime.
package aes_pkg;
    localparam int unsigned AES_NUM_ROUNDS = 10;
    localparam int unsigned AES_KEY_W      = 128;

    typedef logic [3:0] round_idx_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes_key_mem_if.sv
// Key-memory bus: init/key handshake, round-key read port and shared S-box word path.
interface aes_key_mem_if;
    import aes_pkg::*;

    logic                 init;
    logic [AES_KEY_W-1:0] key;
    round_idx_t           round;
    logic [AES_KEY_W-1:0] round_key;
    logic                 ready;
    logic [31:0]          sboxw;
    logic [31:0]          new_sboxw;

    modport master (
        output init, key, round, new_sboxw,
        input  round_key, ready, sboxw
    );

    modport slave (
        input  init, key, round, new_sboxw,
        output round_key, ready, sboxw
    );
endinterface

// File: rtl/aes_key_round.sv
// One AES-128 key-schedule step: next round key from the previous key and SubWord(prev w3).
module aes_key_round
    import aes_pkg::*;
(
    input  logic [AES_KEY_W-1:0] prev_key_i,
    input  logic [31:0]          sub_word_i,
    input  logic [7:0]           rcon_i,
    output logic [AES_KEY_W-1:0] next_key_o
);
    logic [31:0] t, n0, n1, n2, n3;

    always_comb begin
        // Rotating after substitution is equivalent because SubWord is bytewise.
        t  = {sub_word_i[23:0], sub_word_i[31:24]} ^ {rcon_i, 24'h0};
        n0 = prev_key_i[127:96] ^ t;
        n1 = prev_key_i[95:64]  ^ n0;
        n2 = prev_key_i[63:32]  ^ n1;
        n3 = prev_key_i[31:0]   ^ n2;
        next_key_o = {n0, n1, n2, n3};
    end
endmodule

// File: rtl/aes_key_mem.sv
// AES-128 key expansion into an 11-entry round-key register file, one round key per cycle.
module aes_key_mem
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input logic          clk,
    input logic          reset,
    aes_key_mem_if.slave bus
);
    localparam int unsigned NumKeys = NUM_ROUNDS + 1;
    localparam round_idx_t  LastRound = NUM_ROUNDS[3:0];

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StGen  = 1'b1;

    logic [0:0]           state_q, state_d;
    round_idx_t           ctr_q, ctr_d;
    logic [7:0]           rcon_q, rcon_d;
    logic [AES_KEY_W-1:0] prev_q, prev_d;
    logic [AES_KEY_W-1:0] mem_q [NumKeys];

    logic                 wr_en;
    round_idx_t           wr_idx;
    logic [AES_KEY_W-1:0] wr_data;
    logic [AES_KEY_W-1:0] next_key;

    aes_key_round u_round (
        .prev_key_i (prev_q),
        .sub_word_i (bus.new_sboxw),
        .rcon_i     (rcon_q),
        .next_key_o (next_key)
    );

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        rcon_d  = rcon_q;
        prev_d  = prev_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.init) begin
                    state_d = StGen;
                    prev_d  = bus.key;
                    rcon_d  = 8'h01;
                    ctr_d   = 4'd1;
                    wr_en   = 1'b1;
                    wr_data = bus.key;
                end
            end
            StGen: begin
                prev_d  = next_key;
                rcon_d  = xtime(rcon_q);
                ctr_d   = ctr_q + 4'd1;
                wr_en   = 1'b1;
                wr_idx  = ctr_q;
                wr_data = next_key;
                if (ctr_q == LastRound) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ctr_q   <= '0;
            rcon_q  <= 8'h01;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            rcon_q  <= rcon_d;
            prev_q  <= prev_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NumKeys); i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        bus.round_key = '0;
        if (bus.round <= LastRound) bus.round_key = mem_q[bus.round];
    end

    assign bus.ready = (state_q == StIdle);
    assign bus.sboxw = prev_q[31:0];
endmodule

// File: tb/tb_aes_key_mem.sv
// Directed bench for aes_key_mem using FIPS-197 key-expansion vectors and a behavioural S-box.
module tb_aes_key_mem;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    localparam logic [127:0] KeyA1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KeyC1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1R1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] C1R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_key_mem_if bus ();

    aes_key_mem #(.NUM_ROUNDS(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    always_comb begin
        bus.new_sboxw = {sbox(bus.sboxw[31:24]), sbox(bus.sboxw[23:16]),
                         sbox(bus.sboxw[15:8]), sbox(bus.sboxw[7:0])};
    end

    task automatic rd(input logic [3:0] r, output logic [127:0] v);
        bus.round = r;
        #1;
        v = bus.round_key;
    endtask

    // Pulse init for one edge; returns at the negedge just after the accept edge.
    task automatic start(input logic [127:0] k);
        @(negedge clk);
        bus.init = 1'b1;
        bus.key  = k;
        @(negedge clk);
        bus.init = 1'b0;
        bus.key  = ~k;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (!bus.ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        logic [127:0] v;
        n_total++;
        if (bus.ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", bus.ready);
        else n_pass++;
        for (int r = 0; r < 16; r += 5) begin
            rd(4'(r), v);
            n_total++;
            if (v !== 128'h0) $display("FAIL reset_round%0d got %h exp 0", r, v);
            else n_pass++;
        end
    endtask

    task automatic test_fips_a1();
        logic [127:0] v;
        int lat;
        start(KeyA1);
        n_total++;
        if (bus.ready !== 1'b0) $display("FAIL a1_ready_low got %b exp 0", bus.ready);
        else n_pass++;
        wait_ready(lat);
        n_total++;
        if (lat !== 10) $display("FAIL a1_latency got %0d exp 10", lat);
        else n_pass++;
        rd(4'd1, v);
        n_total++;
        if (v !== A1R1) $display("FAIL a1_round1 got %h exp %h", v, A1R1);
        else n_pass++;
        rd(4'd10, v);
        n_total++;
        if (v !== A1R10) $display("FAIL a1_round10 got %h exp %h", v, A1R10);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [127:0] v;
        rd(4'd11, v);
        n_total++;
        if (v !== 128'h0) $display("FAIL oor_round11 got %h exp 0", v);
        else n_pass++;
        rd(4'd15, v);
        n_total++;
        if (v !== 128'h0) $display("FAIL oor_round15 got %h exp 0", v);
        else n_pass++;
    endtask

    task automatic test_fips_c1_reinit();
        logic [127:0] v;
        int lat;
        start(KeyC1);
        wait_ready(lat);
        n_total++;
        if (lat !== 10) $display("FAIL c1_latency got %0d exp 10", lat);
        else n_pass++;
        rd(4'd0, v);
        n_total++;
        if (v !== KeyC1) $display("FAIL c1_round0 got %h exp %h", v, KeyC1);
        else n_pass++;
        rd(4'd1, v);
        n_total++;
        if (v !== C1R1) $display("FAIL c1_round1 got %h exp %h", v, C1R1);
        else n_pass++;
        rd(4'd10, v);
        n_total++;
        if (v !== C1R10) $display("FAIL c1_round10 got %h exp %h", v, C1R10);
        else n_pass++;
    endtask

    task automatic test_init_ignored();
        logic [127:0] v;
        int lat;
        start(KeyA1);
        repeat (4) @(negedge clk);
        bus.init = 1'b1;
        bus.key  = KeyC1;
        @(negedge clk);
        bus.init = 1'b0;
        wait_ready(lat);
        n_total++;
        if (lat !== 5) $display("FAIL ignore_latency_rest got %0d exp 5", lat);
        else n_pass++;
        rd(4'd1, v);
        n_total++;
        if (v !== A1R1) $display("FAIL ignore_round1 got %h exp %h", v, A1R1);
        else n_pass++;
        rd(4'd10, v);
        n_total++;
        if (v !== A1R10) $display("FAIL ignore_round10 got %h exp %h", v, A1R10);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [127:0] v;
        int lat;
        start(KeyC1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if (bus.ready !== 1'b1) $display("FAIL midrst_ready got %b exp 1", bus.ready);
        else n_pass++;
        for (int r = 0; r < 4; r++) begin
            rd(4'(r), v);
            n_total++;
            if (v !== 128'h0) $display("FAIL midrst_round%0d got %h exp 0", r, v);
            else n_pass++;
        end
        @(negedge clk);
        reset = 1'b1;
        start(KeyA1);
        wait_ready(lat);
        rd(4'd1, v);
        n_total++;
        if (v !== A1R1) $display("FAIL midrst_a1_round1 got %h exp %h", v, A1R1);
        else n_pass++;
        rd(4'd10, v);
        n_total++;
        if (v !== A1R10) $display("FAIL midrst_a1_round10 got %h exp %h", v, A1R10);
        else n_pass++;
    endtask

    // init held high: ready should be seen high once every 11 cycles.
    task automatic test_back_to_back();
        logic [127:0] v;
        int highs = 0;
        @(negedge clk);
        bus.init = 1'b1;
        bus.key  = KeyC1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (bus.ready) highs++;
        end
        bus.init = 1'b0;
        n_total++;
        if (highs !== 2) $display("FAIL b2b_ready_highs got %0d exp 2", highs);
        else n_pass++;
        rd(4'd10, v);
        n_total++;
        if (v !== C1R10) $display("FAIL b2b_round10 got %h exp %h", v, C1R10);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.ready !== 1'b1) $display("FAIL b2b_idle got %b exp 1", bus.ready);
        else n_pass++;
    endtask

    initial begin
        bus.init  = 1'b0;
        bus.key   = '0;
        bus.round = '0;
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_fips_a1();
        test_out_of_range();
        test_fips_c1_reinit();
        test_init_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/aes_key_mem.md
# aes_key_mem

AES-128 key-expansion and round-key store. It sits directly upstream of `aes_encipher`. On `init` it expands a 128-bit cipher key into the 11 round keys, at one round key per cycle, and holds them in an internal register file. It then serves any round key combinationally by round index. During expansion it borrows the shared `aes_sbox` through the same `sboxw`/`new_sboxw` word interface that `aes_encipher` uses.

## Interface
Parameters:
- `NUM_ROUNDS`, 10: number of round keys generated after round 0. Fixed at 10 for AES-128; no other value is supported.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `init`  in  1  start expansion; sampled on a rising edge while `ready`=1.
- `key`  in  128  cipher key; sampled only on the accepted `init` edge.
- `round`  in  4  round-key index, 0..10.
- `round_key`  out  128  stored key for `round`; combinational read.
- `ready`  out  1  1 = idle and all round keys valid.
- `sboxw`  out  32  word sent to the shared S-box.
- `new_sboxw`  in  32  S-box result (bytewise SubWord of `sboxw`).

## Operation
- Key words: key[127:96]=w0 … key[31:0]=w3.
- FSM states:
  - IDLE → GEN on `init` while IDLE.
  - GEN → IDLE after the edge that writes round 10.
- Accept edge (init in IDLE):
  - mem[0] ← `key`
  - prev ← `key`
  - rcon ← 8'h01
  - ctr ← 1
  - `ready` ← 0
- Each GEN edge:
  - Compute t = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon, 24'h0}.
  - Compute n0=p0^t, n1=p1^n0, n2=p2^n1, n3=p3^n2.
  - mem[ctr] ← {n0,n1,n2,n3}; prev ← same value.
  - rcon ← xtime(rcon): {rcon[6:0],0} ^ (8'h1b if rcon[7]).
  - ctr ← ctr+1.
- `sboxw` = prev[31:0] at all times. Rotate-after-substitute equals SubWord(RotWord) because SubWord is bytewise.
- `round_key`:
  - = mem[round] for round ≤ 10.
  - = 128'h0 for round 11..15.
- `init` while GEN: ignored; expansion is not restarted.
- Changes to `key` after the accept edge are ignored.
- Reading round keys during GEN:
  - Already-written entries are valid.
  - Unwritten entries hold stale values from the previous expansion.
  - Consumers read only when `ready`=1.
- S-box sharing: the top level gives the S-box to `aes_key_mem` while its `ready`=0, and to `aes_encipher` otherwise. Encryption never starts while `ready`=0.

## Timing
- Reset values (asserted asynchronously):
  - FSM=IDLE, `ready`=1, ctr=0, rcon=8'h01, prev=0.
  - All mem entries 0, so `round_key`=0 for every index.
- Latency:
  - `ready` falls at the accept edge E0.
  - Rounds 1..10 are written at edges E1..E10.
  - `ready` rises at E10. Exactly 10 cycles low; the next `init` is accepted at E11 earliest.
- `new_sboxw` must be valid combinationally within the same cycle as `sboxw`; there is no S-box pipeline stage.
- Reset mid-expansion: immediate return to the reset values above. Partial keys are discarded.
- `init` held high continuously: re-expands every 11 cycles, with identical results for an unchanged `key`.
- rcon sequence over rounds 1..10: 01,02,04,08,10,20,40,80,1b,36. The 80→1b step exercises the xtime reduction.

## Structure
- Shared package `aes_pkg` holds:
  - `AES_NUM_ROUNDS`=10
  - `AES_KEY_W`=128
  - the 4-bit round-index type
  - the `xtime` function (also used by MixColumns in `aes_encipher`)
- Sub-module `aes_key_round`: purely combinational. Inputs prev key, substituted word and rcon; output the next round key.
- `aes_key_mem` itself holds the FSM, counter, rcon register and the 11×128 register file.

## Test plan
- FIPS-197 A.1: key 2b7e151628aed2a6abf7158809cf4f3c, init, wait for `ready` → round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f → round 0 = the key, round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe, round 10 = 13111d7fe3944a17f307a78b4d2b30c5. Then drive `aes_encipher` with pt 00112233445566778899aabbccddeeff → ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- Latency: count cycles between `init` accept and `ready` rise → exactly 10. Pulse `init` at cycle 5 of GEN → ignored, results unchanged.
- Reset (low) at GEN cycle 4 → `ready`=1 immediately, all rounds read 0. New init with the A.1 key then yields correct A.1 keys.
- Out-of-range `round`=11 and `round`=15 → `round_key`=0. Re-init with a different key → round 10 matches the new vector, with no residue from the first key.
